// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: redirect/halt control, instruction-memory port and decode handshake.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned INSTR_W = 16
);
   logic               branch_taken;
   logic [ADDR_W-1:0]  branch_target;
   logic               halt;
   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_out;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_ready;
   logic [ADDR_W-1:0]  pc_out;

   modport master (
      output branch_taken, branch_target, halt, imem_data, instr_ready,
      input  imem_en, imem_addr, instr_valid, instr_out, instr_pc, pc_out
   );

   modport slave (
      input  branch_taken, branch_target, halt, imem_data, instr_ready,
      output imem_en, imem_addr, instr_valid, instr_out, instr_pc, pc_out
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential PCs to a 1-cycle synchronous memory and
// buffers returned words in a 2-entry FIFO towards decode, with branch redirect and halt.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic         clock,
   input  logic         reset_n,
   fetch_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [1:0]        count_q, count_d;
   logic              inflight_q, inflight_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   entry_t            fifo_q [2];
   entry_t            fifo_d [2];
   logic              issue_c, push_c, pop_c;

   // Control registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         fetch_pc_q    <= ADDR_W'(RESET_PC);
         inflight_pc_q <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // Buffer storage carries no reset; validity is tracked by count_q
   always_ff @(posedge clock) begin
      fifo_q <= fifo_d;
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      fifo_d        = fifo_q;
      issue_c       = 1'b0;
      pop_c         = (count_q != 2'd0) && bus.instr_ready;
      push_c        = inflight_q && (state_q != ST_FLUSH);

      case (state_q)
         ST_RUN: begin
            if (bus.halt) state_d = ST_HALT;
            else issue_c = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));
         end
         ST_FLUSH: state_d = bus.halt ? ST_HALT : ST_RUN;
         ST_HALT:  if (!bus.halt) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase

      // Redirect wins over everything and drops all buffered and returning words
      if (bus.branch_taken) begin
         issue_c    = 1'b0;
         push_c     = 1'b0;
         pop_c      = 1'b0;
         state_d    = ST_FLUSH;
         fetch_pc_d = bus.branch_target;
      end else if (issue_c) begin
         fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
         inflight_pc_d = fetch_pc_q;
      end

      inflight_d = issue_c;

      if (push_c) begin
         fifo_d[wr_ptr_q] = '{instr: bus.imem_data, pc: inflight_pc_q};
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_d = ~rd_ptr_q;

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (bus.branch_taken) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end
   end

   // Request is forced low while reset is held so nothing leaks out of the reset state
   assign bus.imem_en     = issue_c & reset_n;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.instr_valid = (count_q != 2'd0);
   assign bus.instr_out   = fifo_q[rd_ptr_q].instr;
   assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;
   assign bus.pc_out      = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random redirect/halt/ready traffic
// compared each cycle against a queue-based reference model.
module tb_fetch_unit;

   localparam int unsigned ADDR_W   = 6;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned RESET_PC = 0;
   localparam int unsigned DEPTH    = 1 << ADDR_W;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned pc;
      int unsigned instr;
   } ent_t;

   int               n_chk = 0;
   int               n_bad = 0;
   logic [INSTR_W-1:0] mem [DEPTH];

   // Reference model: in-order queue of delivered words plus the one outstanding request
   ent_t        m_q[$];
   int unsigned m_pc;
   bit          m_infl;
   int unsigned m_infl_pc;
   bit          m_prev_br;
   bit          m_prev_halt;

   bit          pend_en;
   int unsigned pend_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc        = RESET_PC;
      m_infl      = 1'b0;
      m_infl_pc   = 0;
      m_prev_br   = 1'b0;
      m_prev_halt = 1'b0;
   endtask

   // One clock cycle: apply inputs, check at negedge, advance model, answer memory request
   task automatic cyc(input bit br, input int unsigned tgt, input bit hlt, input bit rdy);
      bit valid, pop, push, issue;
      int occ;
      bus.branch_taken  = br;
      bus.branch_target = ADDR_W'(tgt);
      bus.halt          = hlt;
      bus.instr_ready   = rdy;
      @(negedge clock);
      if (!reset_n) begin
         chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
         chk("rst_valid", 32'(bus.instr_valid), 32'd0);
         chk("rst_pc_out", 32'(bus.pc_out), RESET_PC);
      end else begin
         valid = (m_q.size() != 0);
         pop   = valid && rdy && !br;
         push  = m_infl && !m_prev_br && !br;
         occ   = m_q.size() + int'(m_infl) - int'(valid && rdy);
         issue = !br && !m_prev_br && !m_prev_halt && !hlt && (occ < 2);

         chk("imem_en", 32'(bus.imem_en), 32'(issue));
         if (issue) chk("imem_addr", 32'(bus.imem_addr), m_pc);
         chk("instr_valid", 32'(bus.instr_valid), 32'(valid));
         if (valid) begin
            chk("instr_pc", 32'(bus.instr_pc), m_q[0].pc);
            chk("instr_out", 32'(bus.instr_out), m_q[0].instr);
         end
         chk("pc_out", 32'(bus.pc_out), m_pc);

         if (br) begin
            m_q.delete();
            m_pc   = tgt % DEPTH;
            m_infl = 1'b0;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{pc: m_infl_pc, instr: int'(mem[m_infl_pc])});
            m_infl = issue;
            if (issue) begin
               m_infl_pc = m_pc;
               m_pc      = (m_pc + 1) % DEPTH;
            end
         end
         m_prev_br   = br;
         m_prev_halt = hlt;
      end
      pend_en   = bus.imem_en;
      pend_addr = 32'(bus.imem_addr);
      @(posedge clock);
      #1;
      bus.imem_data = pend_en ? mem[pend_addr] : INSTR_W'($urandom);
   endtask

   task automatic async_reset(input bit rerand);
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      chk("arst_imem_en", 32'(bus.imem_en), 32'd0);
      chk("arst_pc_out", 32'(bus.pc_out), RESET_PC);
      if (rerand) foreach (mem[i]) mem[i] = INSTR_W'($urandom);
      model_reset();
      cyc(1'b0, 0, 1'b0, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1);
      reset_n = 1'b1;
   endtask

   initial begin
      bit hlt;
      foreach (mem[i]) mem[i] = INSTR_W'(i);
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.halt          = 1'b0;
      bus.instr_ready   = 1'b1;
      bus.imem_data     = '0;
      model_reset();

      // Reset held, then streaming with memory word = address
      cyc(1'b0, 0, 1'b0, 1'b1);
      cyc(1'b0, 0, 1'b0, 1'b1);
      reset_n = 1'b1;
      repeat (8) cyc(1'b0, 0, 1'b0, 1'b1);

      // Decode stalled from reset: two issues fill the buffer, then release
      async_reset(1'b0);
      repeat (10) cyc(1'b0, 0, 1'b0, 1'b0);
      chk("stall_pc_out", 32'(bus.pc_out), 32'd2);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_head_pc", 32'(bus.instr_pc), 32'd0);
      repeat (6) cyc(1'b0, 0, 1'b0, 1'b1);

      // Wrap across the top of memory
      cyc(1'b1, 62, 1'b0, 1'b1);
      repeat (8) cyc(1'b0, 0, 1'b0, 1'b1);

      // Redirect while the buffer is full and stalled
      repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 40, 1'b0, 1'b0);
      chk("br_valid_drop", 32'(bus.instr_valid), 32'd0);
      repeat (6) cyc(1'b0, 0, 1'b0, 1'b1);

      // Back-to-back redirects: the newer target wins
      cyc(1'b1, 10, 1'b0, 1'b1);
      cyc(1'b1, 20, 1'b0, 1'b1);
      repeat (5) cyc(1'b0, 0, 1'b0, 1'b1);

      // Halt mid-stream drains the buffer and stops issuing, then resumes
      repeat (3) cyc(1'b0, 0, 1'b0, 1'b1);
      repeat (5) cyc(1'b0, 0, 1'b1, 1'b1);
      repeat (5) cyc(1'b0, 0, 1'b0, 1'b1);

      // Redirect under halt lands in HALT after the flush cycle
      cyc(1'b1, 5, 1'b1, 1'b1);
      repeat (3) cyc(1'b0, 0, 1'b1, 1'b1);
      repeat (4) cyc(1'b0, 0, 1'b0, 1'b1);

      // Reset mid-stream restarts at RESET_PC
      repeat (3) cyc(1'b0, 0, 1'b0, 1'b1);
      async_reset(1'b1);
      repeat (4) cyc(1'b0, 0, 1'b0, 1'b1);

      // Random traffic on random memory contents
      hlt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) hlt = ~hlt;
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, DEPTH - 1), hlt,
             $urandom_range(0, 3) != 0);
         if (i % 1000 == 999) async_reset(1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
